// File: rtl/uart_tx_arb.sv
// Round-robin arbiter that lets NREQ byte sources share one uart_tx, locking the
// channel to one requester for a whole message and releasing idle owners on timeout.
module uart_tx_arb #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [8*NREQ-1:0]   req_data,
    input  logic [NREQ-1:0]     req_vld,
    input  logic [NREQ-1:0]     req_last,
    output logic [NREQ-1:0]     req_rdy,
    output logic [7:0]          tx_d,
    output logic                tx_vld,
    input  logic                tx_rdy,
    output logic [2:0]          grant_id,
    output logic                busy,
    output logic                err_timeout
);

    localparam int              CW      = $clog2(TIMEOUT);
    localparam logic [CW-1:0]   CNT_MAX = CW'(TIMEOUT - 1);
    localparam logic [2:0]      LAST_ID = 3'(NREQ - 1);
    localparam logic [3:0]      NREQ_W  = 4'(NREQ);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    state_t         state_r, state_nx_s;
    logic [2:0]     ptr_r, ptr_nx_s;
    logic [2:0]     grant_r, grant_nx_s;
    logic [CW-1:0]  cnt_r, cnt_nx_s;
    logic [7:0]     tx_d_r;
    logic           tx_vld_r;
    logic           err_r;
    logic           timeout_s;
    logic [7:0]     vld_pad_s, last_pad_s;
    logic [63:0]    data_pad_s;
    logic [7:0]     cur_data_s;
    logic           can_load_s, accept_s;
    logic           found_s;
    logic [2:0]     pick_s;
    logic [3:0]     cand_s;
    logic [2:0]     next_ptr_s;

    // Widen requester buses to 8 lanes so the owner can be indexed by a 3-bit id.
    always_comb begin
        vld_pad_s                 = 8'h00;
        last_pad_s                = 8'h00;
        data_pad_s                = 64'h0;
        vld_pad_s[NREQ-1:0]       = req_vld;
        last_pad_s[NREQ-1:0]      = req_last;
        data_pad_s[8*NREQ-1:0]    = req_data;
    end

    assign cur_data_s = data_pad_s[{grant_r, 3'b000} +: 8];
    assign can_load_s = !tx_vld_r || tx_rdy;
    assign accept_s   = (state_r == ST_LOCK) && vld_pad_s[grant_r] && can_load_s;
    assign next_ptr_s = (grant_r == LAST_ID) ? 3'd0 : grant_r + 3'd1;

    // Rotating search: first valid requester at or above ptr, wrapping modulo NREQ.
    always_comb begin
        found_s = 1'b0;
        pick_s  = 3'd0;
        cand_s  = 4'd0;
        for (int i = 0; i < NREQ; i++) begin
            cand_s = {1'b0, ptr_r} + 4'(i);
            if (cand_s >= NREQ_W) begin
                cand_s = cand_s - NREQ_W;
            end else begin
                cand_s = cand_s;
            end
            if (!found_s && vld_pad_s[cand_s[2:0]]) begin
                found_s = 1'b1;
                pick_s  = cand_s[2:0];
            end else begin
                found_s = found_s;
            end
        end
    end

    // Only the owner may hand over a byte, and only when the output slot frees up.
    always_comb begin
        req_rdy = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_rdy[i] = (state_r == ST_LOCK) && (grant_r == 3'(i)) && can_load_s;
        end
    end

    // Ownership FSM next state: grant, end-of-message release, idle-owner timeout.
    always_comb begin
        state_nx_s = state_r;
        ptr_nx_s   = ptr_r;
        grant_nx_s = grant_r;
        cnt_nx_s   = cnt_r;
        timeout_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                cnt_nx_s = '0;
                if (found_s) begin
                    state_nx_s = ST_LOCK;
                    grant_nx_s = pick_s;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_LOCK: begin
                if (accept_s) begin
                    cnt_nx_s = '0;
                    if (last_pad_s[grant_r]) begin
                        state_nx_s = ST_IDLE;
                        ptr_nx_s   = next_ptr_s;
                    end else begin
                        state_nx_s = ST_LOCK;
                    end
                end else if (!vld_pad_s[grant_r]) begin
                    if (cnt_r == CNT_MAX) begin
                        state_nx_s = ST_IDLE;
                        ptr_nx_s   = next_ptr_s;
                        cnt_nx_s   = '0;
                        timeout_s  = 1'b1;
                    end else begin
                        cnt_nx_s = cnt_r + CW'(1);
                    end
                end else begin
                    cnt_nx_s = '0;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
                cnt_nx_s   = '0;
            end
        endcase
    end

    // State, pointer, owner, idle counter and the timeout pulse register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            ptr_r   <= 3'd0;
            grant_r <= 3'd0;
            cnt_r   <= '0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            ptr_r   <= ptr_nx_s;
            grant_r <= grant_nx_s;
            cnt_r   <= cnt_nx_s;
            err_r   <= timeout_s;
        end
    end

    // Output slot: load on accept, hold under backpressure, empty on consume.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_d_r   <= 8'h00;
            tx_vld_r <= 1'b0;
        end else if (accept_s) begin
            tx_d_r   <= cur_data_s;
            tx_vld_r <= 1'b1;
        end else if (tx_rdy) begin
            tx_vld_r <= 1'b0;
        end else begin
            tx_vld_r <= tx_vld_r;
        end
    end

    assign tx_d        = tx_d_r;
    assign tx_vld      = tx_vld_r;
    assign grant_id    = grant_r;
    assign err_timeout = err_r;
    assign busy        = (state_r == ST_LOCK) || tx_vld_r;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Scoreboard bench for uart_tx_arb: requester models feed byte queues, the monitor
// compares every consumed tx byte against the expected stream.
module tb_uart_tx_arb;

    localparam int NREQ    = 4;
    localparam int TIMEOUT = 16;

    logic                clk = 1'b0;
    logic                reset;
    logic [8*NREQ-1:0]   req_data;
    logic [NREQ-1:0]     req_vld;
    logic [NREQ-1:0]     req_last;
    logic [NREQ-1:0]     req_rdy;
    logic [7:0]          tx_d;
    logic                tx_vld;
    logic                tx_rdy;
    logic [2:0]          grant_id;
    logic                busy;
    logic                err_timeout;

    logic [8:0]  src_q [NREQ][$];
    logic [7:0]  exp_q [$];
    logic [NREQ-1:0] acc;
    int n_checks = 0;
    int n_errors = 0;
    int err_seen = 0;

    uart_tx_arb #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .req_data(req_data), .req_vld(req_vld),
        .req_last(req_last), .req_rdy(req_rdy), .tx_d(tx_d), .tx_vld(tx_vld),
        .tx_rdy(tx_rdy), .grant_id(grant_id), .busy(busy), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_busy(input string name);
        int k;
        k = 0;
        while (!busy && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk(name, 32'(busy), 32'd1);
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || busy) && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk(name, 32'(exp_q.size() == 0 && !busy), 32'd1);
    endtask

    // Requester models: present queue head, pop it once accepted.
    initial begin
        req_vld  = '0;
        req_last = '0;
        req_data = '0;
        acc      = '0;
        forever begin
            @(negedge clk);
            acc = req_vld & req_rdy;
            @(posedge clk);
            #1;
            for (int i = 0; i < NREQ; i++) begin
                if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
                if (src_q[i].size() > 0) begin
                    req_vld[i]         = 1'b1;
                    req_data[8*i +: 8] = src_q[i][0][7:0];
                    req_last[i]        = src_q[i][0][8];
                end else begin
                    req_vld[i]  = 1'b0;
                    req_last[i] = 1'b0;
                end
            end
        end
    end

    // Monitor: compare each consumed byte and count timeout pulses.
    initial begin
        forever begin
            @(negedge clk);
            if (err_timeout) err_seen++;
            if (reset && tx_vld && tx_rdy) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_byte: got 0x%0h, expected no byte", tx_d);
                end else begin
                    chk("tx_byte", 32'(tx_d), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        int n0, n1;
        bit seen;
        reset  = 1'b0;
        tx_rdy = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tx_vld", 32'(tx_vld), 32'd0);
        chk("rst_tx_d", 32'(tx_d), 32'd0);
        chk("rst_req_rdy", 32'(req_rdy), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err_timeout), 32'd0);
        chk("rst_grant", 32'(grant_id), 32'd0);
        step();
        reset  = 1'b1;
        tx_rdy = 1'b1;
        step();

        // single requester, 2-cycle latency, back-to-back bytes
        src_q[0].push_back({1'b0, 8'h41});
        src_q[0].push_back({1'b1, 8'h42});
        exp_q.push_back(8'h41);
        exp_q.push_back(8'h42);
        n0 = -1;
        n1 = -1;
        for (int k = 0; k < 12 && n1 < 0; k++) begin
            @(negedge clk);
            if (n0 < 0 && req_vld[0]) n0 = k;
            if (tx_vld) n1 = k;
        end
        chk("latency", 32'(n1 - n0), 32'd2);
        chk("first_byte", 32'(tx_d), 32'h41);
        @(negedge clk);
        chk("second_byte", 32'({tx_vld, tx_d}), 32'h142);
        @(negedge clk);
        chk("idle_after_msg", 32'(busy), 32'd0);

        // ptr moved to 1: req1 wins over req0
        step();
        src_q[0].push_back({1'b1, 8'h50});
        src_q[1].push_back({1'b1, 8'h60});
        exp_q.push_back(8'h60);
        exp_q.push_back(8'h50);
        wait_busy("busy_ptr1");
        chk("grant_ptr1", 32'(grant_id), 32'd1);
        drain("drain_ptr1");

        // contention from ptr=0: req1 message fully before req3
        step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        step();
        src_q[1].push_back({1'b0, 8'h11});
        src_q[1].push_back({1'b0, 8'h12});
        src_q[1].push_back({1'b1, 8'h13});
        src_q[3].push_back({1'b0, 8'h31});
        src_q[3].push_back({1'b0, 8'h32});
        src_q[3].push_back({1'b1, 8'h33});
        foreach (src_q[1][j]) exp_q.push_back(src_q[1][j][7:0]);
        foreach (src_q[3][j]) exp_q.push_back(src_q[3][j][7:0]);
        wait_busy("busy_contend");
        chk("grant_contend", 32'(grant_id), 32'd1);
        drain("drain_contend");

        // backpressure for 20 cycles on req2
        step();
        tx_rdy = 1'b0;
        src_q[2].push_back({1'b0, 8'hA1});
        src_q[2].push_back({1'b0, 8'hA2});
        src_q[2].push_back({1'b1, 8'hA3});
        exp_q.push_back(8'hA1);
        exp_q.push_back(8'hA2);
        exp_q.push_back(8'hA3);
        for (int k = 0; k < 20 && !tx_vld; k++) @(negedge clk);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk("bp_hold", 32'({tx_vld, tx_d, req_rdy}), 32'({1'b1, 8'hA1, 4'b0000}));
        end
        step();
        tx_rdy = 1'b1;
        drain("drain_bp");

        // owner req1 goes quiet mid-message; req2 waits
        step();
        src_q[1].push_back({1'b0, 8'h71});
        src_q[1].push_back({1'b0, 8'h72});
        src_q[2].push_back({1'b1, 8'h81});
        exp_q.push_back(8'h71);
        exp_q.push_back(8'h72);
        exp_q.push_back(8'h81);
        n0 = -1;
        n1 = -1;
        seen = 1'b0;
        for (int k = 0; k < 100 && n1 < 0; k++) begin
            @(negedge clk);
            if (req_vld[1]) seen = 1'b1;
            else if (seen && n0 < 0) n0 = k;
            if (err_timeout) n1 = k;
        end
        chk("timeout_cycles", 32'(n1 - n0), 32'd16);
        @(negedge clk);
        chk("grant_after_timeout", 32'({busy, grant_id, err_timeout}), 32'({1'b1, 3'd2, 1'b0}));
        drain("drain_timeout");

        // reset while a byte sits in the output slot
        step();
        tx_rdy = 1'b0;
        src_q[3].push_back({1'b0, 8'h91});
        src_q[3].push_back({1'b0, 8'h92});
        src_q[3].push_back({1'b1, 8'h93});
        for (int k = 0; k < 20 && !tx_vld; k++) @(negedge clk);
        chk("pre_reset_vld", 32'(tx_vld), 32'd1);
        step();
        reset = 1'b0;
        src_q[3].delete();
        #1;
        chk("rst_async", 32'({tx_vld, req_rdy, busy, tx_d, err_timeout}), 32'd0);
        step();
        step();
        reset  = 1'b1;
        tx_rdy = 1'b1;
        step();
        src_q[0].push_back({1'b1, 8'hC0});
        src_q[3].push_back({1'b1, 8'hD0});
        exp_q.push_back(8'hC0);
        exp_q.push_back(8'hD0);
        wait_busy("busy_post_reset");
        chk("grant_post_reset", 32'(grant_id), 32'd0);
        drain("drain_post_reset");

        chk("err_pulses", 32'(err_seen), 32'd1);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 Parameter NREQ, default 4, SHALL set the number of byte requesters sharing one uart_tx; legal range 1..8.
REQ-002 Parameter TIMEOUT, default 1024, SHALL set the idle-owner release limit in clk cycles; minimum 2.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  SHALL be an asynchronous, active-low reset.
REQ-005 req_data  input  8*NREQ  SHALL carry the byte of requester i in bits [8i+7:8i].
REQ-006 req_vld  input  NREQ  SHALL flag that requester i offers a byte.
REQ-007 req_last  input  NREQ  SHALL mark requester i's byte as the final byte of its message.
REQ-008 req_rdy  output  NREQ  SHALL accept requester i's byte in any cycle where req_vld[i] and req_rdy[i] are both 1.
REQ-009 tx_d  output  8  SHALL be the byte to the uart_tx data input.
REQ-010 tx_vld  output  1  SHALL be the valid signal to the uart_tx valid input.
REQ-011 tx_rdy  input  1  SHALL be the ready signal from uart_tx; a byte is consumed when tx_vld and tx_rdy are both 1.
REQ-012 grant_id  output  3  SHALL report the current owner index; it is meaningful only while busy is 1.
REQ-013 busy  output  1  SHALL be 1 when state is LOCK or tx_vld is 1.
REQ-014 err_timeout  output  1  SHALL pulse for one cycle when an owner is released by timeout.

Function
REQ-015 The FSM SHALL have two states: IDLE (no owner) and LOCK (owner = grant_id).
REQ-016 In IDLE with any req_vld bit set, the block SHALL select the first set bit searching upward from ptr, wrapping modulo NREQ, and register it into grant_id.
REQ-017 At that same clock edge the FSM SHALL enter LOCK.
REQ-018 No byte SHALL transfer in IDLE; req_rdy SHALL be all 0 in IDLE.
REQ-019 In LOCK, req_rdy[grant_id] SHALL equal (!tx_vld || tx_rdy).
REQ-020 In LOCK, every other req_rdy bit SHALL be 0.
REQ-021 An accepted byte SHALL load tx_d at the next edge and set tx_vld to 1.
REQ-022 The tx_d/tx_vld output register SHALL hold until consumed.
REQ-023 Back-to-back accept and consume SHALL sustain one byte per cycle with no bubble.
REQ-024 tx_vld SHALL clear on consume when no new byte is accepted in the same cycle.
REQ-025 Latency from req_vld rising in IDLE with the output register empty to tx_vld high SHALL be 2 cycles.
REQ-026 An accepted byte with req_last=1 SHALL return the FSM to IDLE and set ptr = (grant_id+1) mod NREQ.
REQ-027 The output register SHALL keep draining after the FSM returns to IDLE.
REQ-028 A new grant SHALL be allowed while the last byte is still pending in the output register.
REQ-029 In LOCK, an idle counter SHALL increment each cycle req_vld[grant_id]=0, and SHALL clear on any cycle that value is 1.
REQ-030 When the idle counter reaches TIMEOUT-1, the block SHALL return to IDLE, advance ptr as in REQ-026, and pulse err_timeout.
REQ-031 Owner-change fairness: the same requester SHALL NOT be granted twice in a row while another requester's req_vld is 1 at arbitration.
REQ-032 Bytes of one message SHALL never interleave with another requester's bytes on tx_d.
REQ-033 With NREQ=1, ptr SHALL remain 0 and behaviour SHALL otherwise be identical.
REQ-034 Requester changes to req_data, req_vld or req_last while req_rdy is 0 SHALL have no effect.

Reset
REQ-035 On reset low, the block SHALL immediately set state=IDLE, ptr=0, grant_id=0, tx_vld=0, tx_d=8'h00, err_timeout=0, idle counter=0, and req_rdy all 0.
REQ-036 Reset mid-message SHALL drop the pending byte and ownership; no partial state SHALL survive release.

Verification
REQ-037 Single requester: req0 sends 8'h41 then 8'h42 (last); tx_rdy=1 -> tx_vld high 2 cycles after req_vld; 41 then 42 on consecutive cycles; FSM back in IDLE; ptr=1.
REQ-038 Contention: req1 and req3 both valid in IDLE with ptr=0; each sends a 3-byte message -> all req1 bytes appear before any req3 byte; next grant goes to 3 without interleave.
REQ-039 Backpressure: tx_rdy held 0 for 20 cycles during a message -> tx_d stable, tx_vld=1, req_rdy[owner]=0; resuming tx_rdy loses and duplicates no byte.
REQ-040 Timeout with TIMEOUT=16: owner drops req_vld mid-message -> release after 16 idle cycles with exactly one err_timeout pulse; waiting req2 granted next.
REQ-041 Reset mid-message: reset low while tx_vld=1 -> tx_vld=0 and req_rdy=0 immediately; after release, req0 granted first.
